// File: rtl/vc_fifo_bank_if.sv
`default_nettype none
// ============================================================================
//  Module : vc_fifo_bank_if
//  Brief  : Write/pop/status bundle between a VC FIFO bank and its neighbours.
//  Rev    : 1.0  initial release
// ============================================================================
interface vc_fifo_bank_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  push;
  logic [1:0]            push_id;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [1:0]            pop_id;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [3:0]            empty;
  logic [3:0]            full;
  logic [3:0]            almost_full;
  logic [3:0]            error;

  // Source/arbiter side.
  modport master (
    output push, push_id, data_in, pop, pop_id,
    input  data_out, valid_out, empty, full, almost_full, error
  );

  // FIFO bank side.
  modport slave (
    input  push, push_id, data_in, pop, pop_id,
    output data_out, valid_out, empty, full, almost_full, error
  );
endinterface
`default_nettype wire

// File: rtl/vc_fifo_bank.sv
`default_nettype none
// ============================================================================
//  Module : vc_fifo_bank
//  Brief  : Four independent per-virtual-channel FIFOs with registered pop
//           output and sticky overflow/underflow flags.
//           Optional macro VC_FIFO_ALMOST_EN builds the almost_full outputs.
//  Rev    : 1.0  initial release
// ============================================================================
module vc_fifo_bank #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = 3
) (
  input  wire logic      clk,
  input  wire logic      reset_L,
  vc_fifo_bank_if.slave  bus
);

  localparam int c_NQ    = 4;
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [c_PTR_W-1:0]    r_wr_ptr [c_NQ];
  logic [c_PTR_W-1:0]    r_rd_ptr [c_NQ];
  logic [c_CNT_W-1:0]    r_cnt    [c_NQ];
  logic [DATA_WIDTH-1:0] r_mem    [c_NQ][DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic [c_NQ-1:0]       r_err;

  logic [c_NQ-1:0]       w_push_hit;
  logic [c_NQ-1:0]       w_pop_hit;
  logic [c_NQ-1:0]       w_push_acc;
  logic [c_NQ-1:0]       w_pop_acc;
  logic [c_NQ-1:0]       w_empty;
  logic [c_NQ-1:0]       w_full;
  logic [c_NQ-1:0]       w_af;
  logic [c_NQ-1:0]       w_err_set;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_params
      $error("vc_fifo_bank: DEPTH must be a power of 2 >= 2 and AF_THRESH in 1..DEPTH");
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < c_NQ; gi++) begin : g_queue
      assign w_push_hit[gi] = bus.push && (bus.push_id == 2'(gi));
      assign w_pop_hit[gi]  = bus.pop  && (bus.pop_id  == 2'(gi));
      assign w_empty[gi]    = (r_cnt[gi] == '0);
      assign w_full[gi]     = (r_cnt[gi] == c_CNT_W'(DEPTH));
      // A pop on the same edge frees the slot, so a full queue still takes the push.
      assign w_push_acc[gi] = w_push_hit[gi] && (!w_full[gi] || w_pop_hit[gi]);
      assign w_pop_acc[gi]  = w_pop_hit[gi] && !w_empty[gi];
      assign w_err_set[gi]  = (w_push_hit[gi] && !w_push_acc[gi]) ||
                              (w_pop_hit[gi]  && w_empty[gi]);
`ifdef VC_FIFO_ALMOST_EN
      assign w_af[gi]       = (r_cnt[gi] >= c_CNT_W'(AF_THRESH));
`else
      assign w_af[gi]       = 1'b0;
`endif
    end
  endgenerate

  // Pointers, occupancy, sticky errors and the registered pop result.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < c_NQ; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_err       <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      for (int i = 0; i < c_NQ; i++) begin
        if (w_push_acc[i]) r_wr_ptr[i] <= r_wr_ptr[i] + c_PTR_W'(1);
        if (w_pop_acc[i])  r_rd_ptr[i] <= r_rd_ptr[i] + c_PTR_W'(1);
        case ({w_push_acc[i], w_pop_acc[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - c_CNT_W'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
        if (w_err_set[i]) r_err[i] <= 1'b1;
      end
      if (|w_pop_acc) begin
        r_data_out  <= r_mem[bus.pop_id][r_rd_ptr[bus.pop_id]];
        r_valid_out <= 1'b1;
      end else begin
        r_valid_out <= 1'b0;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (|w_push_acc) begin
      r_mem[bus.push_id][r_wr_ptr[bus.push_id]] <= bus.data_in;
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.valid_out   = r_valid_out;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.almost_full = w_af;
  assign bus.error       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vc_fifo_bank.sv
`default_nettype none
// ============================================================================
//  Module : tb_vc_fifo_bank
//  Brief  : Directed scoreboard bench for vc_fifo_bank (DEPTH=4, DATA_WIDTH=6).
//  Rev    : 1.0  initial release
// ============================================================================
module tb_vc_fifo_bank;

`ifdef VC_FIFO_ALMOST_EN
  localparam bit c_AF_EN = 1'b1;
`else
  localparam bit c_AF_EN = 1'b0;
`endif

  logic clk;
  logic reset_L;
  int   checks;
  int   errors;
  logic [5:0] exp_q[$];

  vc_fifo_bank_if #(.DATA_WIDTH(6)) bus ();

  vc_fifo_bank #(.DATA_WIDTH(6), .DEPTH(4), .AF_THRESH(3)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the expected pop result, if any, goes to the scoreboard.
  task automatic step(input bit ps, input logic [1:0] pid, input logic [5:0] d,
                      input bit pp, input logic [1:0] qid, input bit pexp, input logic [5:0] dexp);
    bus.push    = ps;
    bus.push_id = pid;
    bus.data_in = d;
    bus.pop     = pp;
    bus.pop_id  = qid;
    if (pexp) exp_q.push_back(dexp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_w(input logic [1:0] id, input logic [5:0] d);
    step(1'b1, id, d, 1'b0, 2'd0, 1'b0, 6'h00);
  endtask

  task automatic pop_w(input logic [1:0] id, input logic [5:0] e);
    step(1'b0, 2'd0, 6'h00, 1'b1, id, 1'b1, e);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0, 6'h00);
  endtask

  // Monitor: every presented word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_L && bus.valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data %h expected no output", bus.data_out);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          errors++;
          $display("FAIL pop_data: got %h expected %h", bus.data_out, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset_L = 1'b0;
    bus.push = 1'b0; bus.push_id = 2'd0; bus.data_in = 6'h00;
    bus.pop  = 1'b0; bus.pop_id  = 2'd0;
    #1;
    check("rst_empty", 8'(bus.empty), 8'h0F);
    check("rst_full",  8'(bus.full),  8'h00);
    check("rst_valid", 8'(bus.valid_out), 8'h00);
    check("rst_data",  8'(bus.data_out), 8'h00);
    check("rst_error", 8'(bus.error), 8'h00);
    check("rst_af",    8'(bus.almost_full), 8'h00);
    @(negedge clk);
    reset_L = 1'b1;

    // Ordering on queue 2.
    push_w(2'd2, 6'h01);
    push_w(2'd2, 6'h02);
    push_w(2'd2, 6'h03);
    check("ord_empty", 8'(bus.empty), 8'h0B);
    pop_w(2'd2, 6'h01);
    pop_w(2'd2, 6'h02);
    pop_w(2'd2, 6'h03);
    check("ord_empty_after", 8'(bus.empty), 8'h0F);

    // Overflow on queue 0.
    push_w(2'd0, 6'h10);
    push_w(2'd0, 6'h11);
    push_w(2'd0, 6'h12);
    check("af_cnt3", 8'(bus.almost_full), c_AF_EN ? 8'h01 : 8'h00);
    push_w(2'd0, 6'h13);
    check("ovf_full4", 8'(bus.full), 8'h01);
    check("ovf_err_before", 8'(bus.error), 8'h00);
    push_w(2'd0, 6'h14);
    check("ovf_full5", 8'(bus.full), 8'h01);
    check("ovf_err", 8'(bus.error), 8'h01);
    pop_w(2'd0, 6'h10);
    check("af_pop_cnt3", 8'(bus.almost_full), c_AF_EN ? 8'h01 : 8'h00);
    pop_w(2'd0, 6'h11);
    check("af_pop_cnt2", 8'(bus.almost_full), 8'h00);
    pop_w(2'd0, 6'h12);
    pop_w(2'd0, 6'h13);
    check("ovf_drained", 8'(bus.empty), 8'h0F);

    // Underflow on queue 3 while queue 1 holds one word.
    push_w(2'd1, 6'h20);
    step(1'b0, 2'd0, 6'h00, 1'b1, 2'd3, 1'b0, 6'h00);
    check("udf_valid", 8'(bus.valid_out), 8'h00);
    check("udf_err", 8'(bus.error), 8'h09);
    check("udf_empty", 8'(bus.empty), 8'h0D);

    // Same-queue push+pop while full.
    push_w(2'd1, 6'h21);
    push_w(2'd1, 6'h22);
    push_w(2'd1, 6'h23);
    check("sq_full_before", 8'(bus.full), 8'h02);
    step(1'b1, 2'd1, 6'h2A, 1'b1, 2'd1, 1'b1, 6'h20);
    check("sq_full_after", 8'(bus.full), 8'h02);
    check("sq_err", 8'(bus.error), 8'h09);
    pop_w(2'd1, 6'h21);
    pop_w(2'd1, 6'h22);
    pop_w(2'd1, 6'h23);
    pop_w(2'd1, 6'h2A);
    check("sq_drained", 8'(bus.empty), 8'h0F);

    // Push and pop on different queues together.
    push_w(2'd2, 6'h31);
    step(1'b1, 2'd3, 6'h32, 1'b1, 2'd2, 1'b1, 6'h31);
    check("dq_empty", 8'(bus.empty), 8'h07);
    pop_w(2'd3, 6'h32);

    // Push+pop on an empty queue: push stored, pop rejected.
    step(1'b1, 2'd0, 6'h3C, 1'b1, 2'd0, 1'b0, 6'h00);
    check("eq_valid", 8'(bus.valid_out), 8'h00);
    check("eq_empty", 8'(bus.empty), 8'h0E);
    pop_w(2'd0, 6'h3C);

    // Pointer wrap on queue 0.
    for (int k = 0; k < 10; k++) begin
      push_w(2'd0, 6'(6'h05 + k));
      pop_w(2'd0, 6'(6'h05 + k));
    end
    check("wrap_empty", 8'(bus.empty), 8'h0F);

    // Asynchronous reset with a pop result in flight.
    push_w(2'd1, 6'h35);
    push_w(2'd2, 6'h36);
    push_w(2'd3, 6'h37);
    bus.push = 1'b0;
    bus.pop = 1'b1;
    bus.pop_id = 2'd1;
    @(posedge clk);
    #1;
    bus.pop = 1'b0;
    check("mid_valid_pre", 8'(bus.valid_out), 8'h01);
    check("mid_data_pre", 8'(bus.data_out), 8'h35);
    #1;
    reset_L = 1'b0;
    #1;
    check("mid_rst_empty", 8'(bus.empty), 8'h0F);
    check("mid_rst_full", 8'(bus.full), 8'h00);
    check("mid_rst_valid", 8'(bus.valid_out), 8'h00);
    check("mid_rst_data", 8'(bus.data_out), 8'h00);
    check("mid_rst_error", 8'(bus.error), 8'h00);
    @(negedge clk);
    reset_L = 1'b1;
    idle();
    check("post_rst_empty", 8'(bus.empty), 8'h0F);
    idle();
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
